dff_write_arbiter: RTL and testbench

DFF_WRITE_ARBITER -- requirements
Module: dff_write_arbiter

---
 rtl/dff_arb_pkg.sv | 9 +
 rtl/dff_reg.sv | 17 +
 rtl/dff_write_arbiter.sv | 109 ++++++++++
 tb/tb_dff_write_arbiter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dff_arb_pkg.sv
// Shared types and default sizing for the round-robin shared-register writer.
package dff_arb_pkg;

  typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} state_t;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_WIDTH = 8;

endpackage

// File: rtl/dff_reg.sv
// WIDTH-bit load-enabled register, asynchronously cleared to zero.
module dff_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/dff_write_arbiter.sv
// Round-robin arbiter granting NREQ writers one at a time into a shared register.
// Define ARB_LOCK_EN to add a lock input that keeps the current winner in WRITE.
module dff_write_arbiter
  import dff_arb_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*WIDTH-1:0]    wdata,
`ifdef ARB_LOCK_EN
  input  logic                     lock,
`endif
  output logic [NREQ-1:0]          gnt,
  output logic [WIDTH-1:0]         q,
  output logic                     q_valid,
  output logic [$clog2(NREQ)-1:0]  owner,
  output logic                     busy
);

  localparam int IW = $clog2(NREQ);
  localparam logic [NREQ-1:0] GNT_ONE = {{(NREQ-1){1'b0}}, 1'b1};

  state_t          state;
  logic [IW-1:0]   winner, rr_ptr, pick, sel;
  logic            hit, held, stay, load;
  int              idx;
  logic [WIDTH-1:0] slice [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_slice
    assign slice[g] = wdata[g*WIDTH +: WIDTH];
  end

  // First set request at or above rr_ptr, wrapping at NREQ.
  always_comb begin
    pick = '0;
    hit  = 1'b0;
    idx  = 0;
    sel  = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      sel = IW'(idx);
      if (!hit && req[sel]) begin
        hit  = 1'b1;
        pick = sel;
      end
    end
  end

  assign held = req[winner];
`ifdef ARB_LOCK_EN
  assign stay = lock & held;
`else
  assign stay = 1'b0;
`endif
  assign load = (state == WRITE) && held;
  assign busy = (state == WRITE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      gnt     <= '0;
      winner  <= '0;
      rr_ptr  <= '0;
      q_valid <= 1'b0;
      owner   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hit) begin
            winner <= pick;
            gnt    <= GNT_ONE << pick;
            state  <= WRITE;
          end else begin
            gnt <= '0;
          end
        end
        WRITE: begin
          if (held) begin
            q_valid <= 1'b1;
            owner   <= winner;
          end
          // A locked winner keeps its grant; rr_ptr only moves on the final write.
          if (!stay) begin
            if (held) rr_ptr <= (winner == IW'(NREQ-1)) ? '0 : winner + 1'b1;
            gnt   <= '0;
            state <= IDLE;
          end
        end
        default: begin
          gnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  dff_reg #(.WIDTH(WIDTH)) u_q (
    .clk (clk),
    .rst (rst),
    .en  (load),
    .d   (slice[winner]),
    .q   (q)
  );

endmodule

// File: tb/tb_dff_write_arbiter.sv
// Scoreboard bench for dff_write_arbiter: a transaction model predicts grants and writes.
module tb_dff_write_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam logic [NREQ-1:0]       ONE  = 1;
  localparam logic [NREQ*WIDTH-1:0] MASK = {{((NREQ-1)*WIDTH){1'b0}}, {WIDTH{1'b1}}};

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NREQ-1:0]        req;
  logic [NREQ*WIDTH-1:0]  wdata;
  logic                   lock;
  logic [NREQ-1:0]        gnt;
  logic [WIDTH-1:0]       q;
  logic                   q_valid;
  logic [1:0]             owner;
  logic                   busy;

  always #5 clk = ~clk;

  dff_write_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .wdata   (wdata),
`ifdef ARB_LOCK_EN
    .lock    (lock),
`endif
    .gnt     (gnt),
    .q       (q),
    .q_valid (q_valid),
    .owner   (owner),
    .busy    (busy)
  );

  typedef struct {
    logic [WIDTH-1:0] data;
    int               idx;
  } wr_t;

  int vectors = 0;
  int miscompares = 0;

  wr_t             wq[$];
  logic [NREQ-1:0] gq[$];
  logic            bq[$];
  int              owner_log[$];

  bit              m_busy;
  int              m_rr, m_win;
  logic [WIDTH-1:0] exp_q;
  int              exp_owner;
  logic            exp_valid;
  logic [NREQ-1:0] prev_gnt;
  bit              mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic bit_of(input logic [NREQ-1:0] v, input int i);
    logic [NREQ-1:0] t;
    t = v >> i;
    return t[0];
  endfunction

  function automatic logic [WIDTH-1:0] slc(input logic [NREQ*WIDTH-1:0] d, input int i);
    return WIDTH'(d >> (i*WIDTH));
  endfunction

  // Reference: one arbitration or one write attempt per clock, per the written rules.
  task automatic model_step(input logic [NREQ-1:0] r, input logic [NREQ*WIDTH-1:0] d, input logic lk);
    bit found;
    int c;
    wr_t w;
    if (!m_busy) begin
      found = 0;
      for (int k = 0; k < NREQ; k++) begin
        c = (m_rr + k) % NREQ;
        if (!found && bit_of(r, c)) begin
          found = 1;
          m_win = c;
        end
      end
      if (found) m_busy = 1;
    end else if (bit_of(r, m_win)) begin
      w.data = slc(d, m_win);
      w.idx  = m_win;
      wq.push_back(w);
`ifdef ARB_LOCK_EN
      if (!lk) begin
        m_rr = (m_win + 1) % NREQ;
        m_busy = 0;
      end
`else
      m_rr = (m_win + 1) % NREQ;
      m_busy = 0;
`endif
    end else begin
      m_busy = 0;
    end
    gq.push_back(m_busy ? (ONE << m_win) : '0);
    bq.push_back(m_busy);
  endtask

  task automatic model_reset();
    m_busy = 0; m_rr = 0; m_win = 0;
    wq.delete(); gq.delete(); bq.delete();
    exp_q = '0; exp_owner = 0; exp_valid = 1'b0; prev_gnt = '0;
  endtask

  task automatic apply(input logic [NREQ-1:0] r, input logic [NREQ*WIDTH-1:0] d, input logic lk);
    req = r; wdata = d; lock = lk;
    model_step(r, d, lk);
  endtask

  task automatic step(input logic [NREQ-1:0] r, input logic [NREQ*WIDTH-1:0] d, input logic lk);
    @(negedge clk);
    apply(r, d, lk);
  endtask

  // Monitor: a write happened at the last edge if the granted requester was still asking.
  initial forever begin
    @(posedge clk);
    #1;
    if (mon_en) begin
      if ((prev_gnt & req) != '0) begin
        if (wq.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL write_unexpected: gnt %0h req %0h, no write predicted", prev_gnt, req);
        end else begin
          wr_t w;
          w = wq.pop_front();
          exp_q = w.data; exp_owner = w.idx; exp_valid = 1'b1;
        end
        owner_log.push_back(int'(owner));
      end
      if (gq.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL gnt_queue: got %0h with no prediction", gnt);
      end else begin
        chk("gnt", 32'(gnt), 32'(gq.pop_front()));
        chk("busy", 32'(busy), 32'(bq.pop_front()));
      end
      chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
      chk("q", 32'(q), 32'(exp_q));
      chk("owner", 32'(owner), 32'(exp_owner));
      chk("q_valid", 32'(q_valid), 32'(exp_valid));
      prev_gnt = gnt;
    end
  end

  logic [NREQ-1:0]       a_req, a_done;
  logic [NREQ*WIDTH-1:0] a_wd;

  initial begin
    rst = 1'b1; req = '0; wdata = '0; lock = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_q", 32'(q), 32'd0);
    chk("rst_q_valid", 32'(q_valid), 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    apply('0, '0, 1'b0);

    // Fairness: all four held, grants rotate 0,1,2,3,0.
    owner_log.delete();
    repeat (10) step(4'b1111, 32'h44332211, 1'b0);
    step('0, '0, 1'b0);
    chk("fair_count", 32'(owner_log.size()), 32'd5);
    for (int i = 0; i < 5 && i < owner_log.size(); i++)
      chk("fair_order", 32'(owner_log[i]), 32'(i % 4));

    // Single requester 2: grant at n+1, data at n+2.
    step(4'b0100, 32'h00A50000, 1'b0);
    @(negedge clk);
    chk("single_gnt", 32'(gnt), 32'b0100);
    apply(4'b0100, 32'h00A50000, 1'b0);
    step('0, '0, 1'b0);
    chk("single_q", 32'(q), 32'hA5);
    chk("single_owner", 32'(owner), 32'd2);
    chk("single_valid", 32'(q_valid), 32'd1);

    // Wrap: pointer now at 3, so 3 then 0.
    owner_log.delete();
    repeat (4) step(4'b1001, 32'h99000090, 1'b0);
    step('0, '0, 1'b0);
    chk("wrap_count", 32'(owner_log.size()), 32'd2);
    if (owner_log.size() == 2) begin
      chk("wrap_first", 32'(owner_log[0]), 32'd3);
      chk("wrap_second", 32'(owner_log[1]), 32'd0);
    end

    // Withdrawal: requester 1 drops in its grant cycle; pointer must not move.
    owner_log.delete();
    step(4'b0010, 32'h00003C00, 1'b0);
    @(negedge clk);
    chk("wd_gnt", 32'(gnt), 32'b0010);
    apply('0, 32'h00003C00, 1'b0);
    step(4'b0110, 32'h00773C00, 1'b0);
    chk("wd_q_kept", 32'(q), 32'h90);
    @(negedge clk);
    chk("wd_regnt", 32'(gnt), 32'b0010);
    apply(4'b0110, 32'h00773C00, 1'b0);
    step('0, '0, 1'b0);
    step('0, '0, 1'b0);
    chk("wd_owner_log", 32'(owner_log.size() == 1 && owner_log[0] == 1), 32'd1);
    chk("wd_q_new", 32'(q), 32'h3C);

`ifdef ARB_LOCK_EN
    // Lock: requester 0 keeps WRITE and q tracks its data; requester 1 follows.
    step(4'b0011, 32'h0000E101, 1'b1);
    for (int v = 1; v <= 3; v++) begin
      @(negedge clk);
      chk("lock_gnt", 32'(gnt), 32'b0001);
      if (v > 1) chk("lock_q", 32'(q), 32'(v - 1));
      apply(4'b0011, 32'h0000E100 | 32'(v), 1'b1);
    end
    @(negedge clk);
    chk("lock_q3", 32'(q), 32'h03);
    apply(4'b0011, 32'h0000E103, 1'b0);
    step(4'b0010, 32'h0000E100, 1'b0);
    @(negedge clk);
    chk("lock_next_gnt", 32'(gnt), 32'b0010);
    apply(4'b0010, 32'h0000E100, 1'b0);
    step('0, '0, 1'b0);
    chk("lock_next_q", 32'(q), 32'hE1);
`endif

    // Random traffic from protocol-following requesters, with occasional withdrawals.
    a_req = '0; a_done = '0; a_wd = '0;
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        if (bit_of(a_done, i)) begin
          a_req = a_req & ~(ONE << i);
          a_done = a_done & ~(ONE << i);
        end else if (bit_of(a_req, i) && bit_of(gnt, i)) begin
          if ($urandom_range(7) == 0) a_req = a_req & ~(ONE << i);
          else a_done = a_done | (ONE << i);
        end else if (!bit_of(a_req, i) && $urandom_range(2) == 0) begin
          a_req = a_req | (ONE << i);
          a_wd = (a_wd & ~(MASK << (i*WIDTH))) |
                 ((NREQ*WIDTH)'($urandom_range(255)) << (i*WIDTH));
        end
      end
      apply(a_req, a_wd, 1'b0);
    end
    step('0, '0, 1'b0);
    step('0, '0, 1'b0);

    // Reset in the middle of WRITE, then arbitration restarts at requester 0.
    step(4'b0001, 32'h0000005A, 1'b0);
    step(4'b0001, 32'h0000005A, 1'b0);
    step('0, '0, 1'b0);
    step(4'b1000, 32'h6B000000, 1'b0);
    @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    apply(4'b1000, 32'h6B000000, 1'b0);
    #2;
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("async_gnt", 32'(gnt), 32'd0);
    chk("async_q", 32'(q), 32'd0);
    chk("async_q_valid", 32'(q_valid), 32'd0);
    chk("async_owner", 32'(owner), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    owner_log.delete();
    mon_en = 1'b1;
    apply(4'b1111, 32'hD4C3B2A1, 1'b0);
    @(negedge clk);
    chk("post_rst_gnt", 32'(gnt), 32'b0001);
    apply(4'b1111, 32'hD4C3B2A1, 1'b0);
    step('0, '0, 1'b0);
    chk("post_rst_q", 32'(q), 32'hA1);
    step('0, '0, 1'b0);
    @(negedge clk);
    mon_en = 1'b0;
    chk("writes_drained", 32'(wq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
